// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command encoding for the counter register's
// priority mux and the default datapath width.
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_HOLD    = 3'd0;
    localparam cmd_t CMD_CLEAR   = 3'd1;
    localparam cmd_t CMD_DEC     = 3'd2;
    localparam cmd_t CMD_INC     = 3'd3;
    localparam cmd_t CMD_LOAD    = 3'd4;
    localparam cmd_t CMD_RESTORE = 3'd5;

endpackage

// File: rtl/counter_reg_arith.sv
// Combinational step calculator for counter_reg: one instance per direction.
// Works at WIDTH+1 bits so an up-step past MODULUS-1 is seen before any
// truncation; reports whether the step crossed the 0 / MODULUS-1 boundary.
module counter_reg_arith #(
    parameter int WIDTH   = 4,
    parameter int STEP    = 1,
    parameter int MODULUS = 2 ** WIDTH,
    parameter int SAT     = 0,
    parameter bit UP      = 1'b1
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nextVal,
    output logic             crossed
);

    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0] STEP_X = XW'(STEP);
    localparam logic [XW-1:0] MOD_X  = XW'(MODULUS);
    localparam logic [XW-1:0] MAX_X  = XW'(MODULUS - 1);

    logic [XW-1:0] curX;
    logic [XW-1:0] result;

    // Step by STEP in the configured direction, then wrap or saturate.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        curX    = {1'b0, cur};
        result  = curX;
        crossed = 1'b0;
        if (UP) begin
            result = curX + STEP_X;
            if (result > MAX_X) begin
                crossed = 1'b1;
                result  = (SAT != 0) ? MAX_X : result - MOD_X;
            end
        end else begin
            if (curX >= STEP_X) begin
                result = curX - STEP_X;
            end else begin
                crossed = 1'b1;
                result  = (SAT != 0) ? '0 : curX + MOD_X - STEP_X;
            end
        end
        nextVal = WIDTH'(result);
    end

endmodule

// File: rtl/counter_reg.sv
// Loadable up/down counter register (program counter, loop counters,
// address pointers). Priority: load > inc > dec > clear > hold.
// Optional snapshot shadow register enabled by COUNTER_REG_SNAPSHOT_EN
// (adds save/restore/shadow; restore outranks load).
module counter_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int STEP      = 1,
    parameter int MODULUS   = 2 ** WIDTH,
    parameter int SAT       = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
`ifdef COUNTER_REG_SNAPSHOT_EN
    input  logic             save,
    input  logic             restore,
    output logic [WIDTH-1:0] shadow,
`endif
    input  logic [WIDTH-1:0] regInput,
    output logic [WIDTH-1:0] regOutput,
    output logic             wrapEvt,
    output logic             ovf,
    output logic             loadErr
);

    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0]    MOD_X   = XW'(MODULUS);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

    cmd_t             cmd;
    logic             loadOk;
    logic [WIDTH-1:0] upVal;
    logic [WIDTH-1:0] downVal;
    logic             upCross;
    logic             downCross;
    logic [WIDTH-1:0] countNext;
    logic             ovfNext;
    logic             wrapNext;
    logic             loadErrNext;

    counter_reg_arith #(
        .WIDTH(WIDTH), .STEP(STEP), .MODULUS(MODULUS), .SAT(SAT), .UP(1'b1)
    ) upPath (
        .cur(regOutput), .nextVal(upVal), .crossed(upCross)
    );

    counter_reg_arith #(
        .WIDTH(WIDTH), .STEP(STEP), .MODULUS(MODULUS), .SAT(SAT), .UP(1'b0)
    ) downPath (
        .cur(regOutput), .nextVal(downVal), .crossed(downCross)
    );

    assign loadOk = ({1'b0, regInput} < MOD_X);

    // Pick exactly one command; later assignments override earlier ones,
    // so the list runs from lowest to highest priority.
    always_comb begin
        cmd = CMD_HOLD;
        if (clear)   cmd = CMD_CLEAR;
        if (dec)     cmd = CMD_DEC;
        if (inc)     cmd = CMD_INC;
        if (load)    cmd = CMD_LOAD;
`ifdef COUNTER_REG_SNAPSHOT_EN
        if (restore) cmd = CMD_RESTORE;
`endif
    end

    // Next count and flags for the selected command; pulses default low.
    always_comb begin
        countNext   = regOutput;
        ovfNext     = ovf;
        wrapNext    = 1'b0;
        loadErrNext = 1'b0;
        case (cmd)
            CMD_LOAD: begin
                if (loadOk) countNext   = regInput;
                else        loadErrNext = 1'b1;
            end
            CMD_INC: begin
                countNext = upVal;
                if (upCross) begin
                    wrapNext = 1'b1;
                    ovfNext  = 1'b1;
                end
            end
            CMD_DEC: begin
                countNext = downVal;
                if (downCross) begin
                    wrapNext = 1'b1;
                    ovfNext  = 1'b1;
                end
            end
            CMD_CLEAR: begin
                countNext = '0;
                ovfNext   = 1'b0;
            end
`ifdef COUNTER_REG_SNAPSHOT_EN
            CMD_RESTORE: countNext = shadow;
`endif
            default: ;
        endcase
    end

    // Count and flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            regOutput <= RST_CNT;
            wrapEvt   <= 1'b0;
            ovf       <= 1'b0;
            loadErr   <= 1'b0;
        end else begin
            regOutput <= countNext;
            wrapEvt   <= wrapNext;
            ovf       <= ovfNext;
            loadErr   <= loadErrNext;
        end
    end

`ifdef COUNTER_REG_SNAPSHOT_EN
    // Shadow captures the pre-update count; save+restore therefore swaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    shadow <= RST_CNT;
        else if (save) shadow <= regOutput;
    end
`endif

endmodule

// File: tb/tb_counter_reg.sv
// Bench for counter_reg: a wrapping and a saturating instance (WIDTH=4,
// MODULUS=10, STEP=3) share stimulus; an integer-arithmetic model is
// compared every cycle, and literal expectations pin key results.
// Snapshot checks are compiled in with COUNTER_REG_SNAPSHOT_EN.
module tb_counter_reg;

    localparam int W = 4;
    localparam int M = 10;
    localparam int S = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0, inc = 1'b0, dec = 1'b0, clear = 1'b0;
    logic save = 1'b0, restore = 1'b0;
    logic [W-1:0] regInput = '0;

    logic [W-1:0] out0, out1, shd0, shd1;
    logic wrap0, wrap1, ovf0, ovf1, err0, err1;

    int nChecks = 0;
    int nErrors = 0;
    bit chkEn = 1'b0;

    always #5 clk = ~clk;

    counter_reg #(.WIDTH(W), .STEP(S), .MODULUS(M), .SAT(0), .RESET_VAL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .clear(clear),
`ifdef COUNTER_REG_SNAPSHOT_EN
        .save(save), .restore(restore), .shadow(shd0),
`endif
        .regInput(regInput), .regOutput(out0), .wrapEvt(wrap0), .ovf(ovf0), .loadErr(err0)
    );

    counter_reg #(.WIDTH(W), .STEP(S), .MODULUS(M), .SAT(1), .RESET_VAL(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .clear(clear),
`ifdef COUNTER_REG_SNAPSHOT_EN
        .save(save), .restore(restore), .shadow(shd1),
`endif
        .regInput(regInput), .regOutput(out1), .wrapEvt(wrap1), .ovf(ovf1), .loadErr(err1)
    );

`ifndef COUNTER_REG_SNAPSHOT_EN
    assign shd0 = '0;
    assign shd1 = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 wraps, index 1 saturates.
    int  mCount[2], mShadow[2];
    bit  mWrap[2], mOvf[2], mErr[2];
    int  tCount, tOld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mCount[i] = 0; mShadow[i] = 0;
                mWrap[i] = 0; mOvf[i] = 0; mErr[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                tOld   = mCount[i];
                tCount = tOld;
                mWrap[i] = 0;
                mErr[i]  = 0;
                if (restore) begin
                    tCount = mShadow[i];
                end else if (load) begin
                    if (int'(regInput) < M) tCount = int'(regInput);
                    else mErr[i] = 1;
                end else if (inc) begin
                    tCount = tOld + S;
                    if (tCount > M - 1) begin
                        mWrap[i] = 1; mOvf[i] = 1;
                        tCount = (i == 1) ? M - 1 : tCount - M;
                    end
                end else if (dec) begin
                    tCount = tOld - S;
                    if (tCount < 0) begin
                        mWrap[i] = 1; mOvf[i] = 1;
                        tCount = (i == 1) ? 0 : tCount + M;
                    end
                end else if (clear) begin
                    tCount = 0; mOvf[i] = 0;
                end
                if (save) mShadow[i] = tOld;
                mCount[i] = tCount;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            check("cnt0", 32'(out0), 32'(mCount[0]));
            check("cnt1", 32'(out1), 32'(mCount[1]));
            check("wrap0", 32'(wrap0), 32'(mWrap[0]));
            check("wrap1", 32'(wrap1), 32'(mWrap[1]));
            check("ovf0", 32'(ovf0), 32'(mOvf[0]));
            check("ovf1", 32'(ovf1), 32'(mOvf[1]));
            check("err0", 32'(err0), 32'(mErr[0]));
            check("err1", 32'(err1), 32'(mErr[1]));
`ifdef COUNTER_REG_SNAPSHOT_EN
            check("shd0", 32'(shd0), 32'(mShadow[0]));
            check("shd1", 32'(shd1), 32'(mShadow[1]));
`endif
        end
    end

    // Drive one command cycle; returns just after the result is visible.
    task automatic apply(input bit l, input bit i, input bit d, input bit c,
                         input int v, input bit sv = 1'b0, input bit rs = 1'b0);
        load = l; inc = i; dec = d; clear = c; save = sv; restore = rs;
        regInput = W'(v);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_lit(input string tag, input int c0, input int c1,
                              input bit w0, input bit w1, input bit o0, input bit o1,
                              input bit e);
        check({tag, ".cnt0"}, 32'(out0), 32'(c0));
        check({tag, ".cnt1"}, 32'(out1), 32'(c1));
        check({tag, ".wrap0"}, 32'(wrap0), 32'(w0));
        check({tag, ".wrap1"}, 32'(wrap1), 32'(w1));
        check({tag, ".ovf0"}, 32'(ovf0), 32'(o0));
        check({tag, ".ovf1"}, 32'(ovf1), 32'(o1));
        check({tag, ".err0"}, 32'(err0), 32'(e));
        check({tag, ".err1"}, 32'(err1), 32'(e));
    endtask

    initial begin
        @(negedge clk); @(negedge clk); #1;
        expect_lit("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        chkEn = 1'b1;

        apply(1, 0, 0, 0, 7);  expect_lit("load7", 7, 7, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 6);
        apply(0, 1, 0, 0, 0);  expect_lit("inc6to9", 9, 9, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 3);
        apply(0, 0, 1, 0, 0);  expect_lit("dec3to0", 0, 0, 0, 0, 0, 0, 0);

        apply(1, 0, 0, 0, 8);  expect_lit("load8", 8, 8, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);  expect_lit("inc8", 1, 9, 1, 1, 1, 1, 0);
        apply(0, 1, 0, 0, 0);  expect_lit("inc_again", 4, 9, 0, 1, 1, 1, 0);
        apply(0, 0, 0, 0, 0);  expect_lit("hold", 4, 9, 0, 0, 1, 1, 0);
        apply(1, 0, 0, 0, 1);
        apply(0, 0, 1, 0, 0);  expect_lit("dec1", 8, 0, 1, 1, 1, 1, 0);

        apply(1, 1, 1, 1, 5);  expect_lit("all_cmds", 5, 5, 0, 0, 1, 1, 0);
        apply(0, 1, 1, 0, 0);  expect_lit("inc_dec", 8, 8, 0, 0, 1, 1, 0);
        apply(0, 0, 0, 1, 0);  expect_lit("clear", 0, 0, 0, 0, 0, 0, 0);

        apply(1, 0, 0, 0, 9);
        apply(0, 1, 0, 0, 0);  expect_lit("inc9", 2, 9, 1, 1, 1, 1, 0);
        apply(1, 0, 0, 0, 12); expect_lit("load12", 2, 9, 0, 0, 1, 1, 1);
        apply(1, 0, 0, 0, 10); expect_lit("load10", 2, 9, 0, 0, 1, 1, 1);
        apply(0, 0, 0, 0, 0);  expect_lit("err_drop", 2, 9, 0, 0, 1, 1, 0);
        apply(1, 0, 0, 1, 15); expect_lit("load15_clr", 2, 9, 0, 0, 1, 1, 1);

        // Asynchronous reset in the middle of the low phase.
        #2 rst_n = 1'b0;
        #1 expect_lit("midreset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;

`ifdef COUNTER_REG_SNAPSHOT_EN
        apply(1, 0, 0, 0, 6);
        apply(0, 0, 0, 0, 0, 1, 0);
        check("save.shd0", 32'(shd0), 32'd6);
        apply(0, 1, 0, 0, 0);
        check("inc.cnt0", 32'(out0), 32'd9);
        apply(1, 0, 0, 0, 2, 0, 1);
        check("restore.cnt0", 32'(out0), 32'd6);
        check("restore.cnt1", 32'(out1), 32'd6);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 1);
        check("swap.cnt0", 32'(out0), 32'd6);
        check("swap.shd0", 32'(shd0), 32'd9);
        check("swap.shd1", 32'(shd1), 32'd9);
        apply(0, 1, 0, 0, 0, 1, 0);
        check("save_inc.shd0", 32'(shd0), 32'd6);
        check("save_inc.cnt0", 32'(out0), 32'd9);
`endif

        apply(0, 0, 0, 0, 0);
        chkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/counter_reg.md
Name: counter_reg

Overview:
- Parametrised loadable up/down counter register; next generation of the CPU's fixed 4-bit load/inc/clear register.
- Used for the program counter, loop counters and address pointers.
- Adds configurable width, step and modulus, plus decrement, wrap or saturate mode, an event pulse, a sticky overflow flag and a load-range check.

Parameters:
- WIDTH, 4: register width in bits.
- STEP, 1: increment/decrement amount, 1..MODULUS-1.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- SAT, 0: 0 = wrap modulo MODULUS; 1 = saturate at 0 and MODULUS-1.
- RESET_VAL, 0: value of count after reset; must be < MODULUS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  load regInput.
- inc  in  1  count up by STEP.
- dec  in  1  count down by STEP.
- clear  in  1  synchronous clear to 0.
- regInput  in  WIDTH  load value.
- regOutput  out  WIDTH  current count, registered.
- wrapEvt  out  1  one-cycle pulse: the previous cycle's inc/dec crossed a range boundary.
- ovf  out  1  sticky boundary-crossing flag.
- loadErr  out  1  one-cycle pulse: the previous cycle's load was out of range.

Behaviour:
- Reset (asynchronous, any time, including mid-count): regOutput=RESET_VAL, wrapEvt=0, ovf=0, loadErr=0.
- All other updates occur on the rising edge of clk.
- Command priority per cycle, exactly one action: load > inc > dec > clear > hold.
  - Simultaneous inc and dec: inc wins.
  - Simultaneous load and clear: load wins. This matches the predecessor.
- Load:
  - If regInput < MODULUS: regOutput <= regInput.
  - Otherwise: regOutput holds and loadErr pulses next cycle.
  - Load never affects ovf.
- Inc, computed at WIDTH+1 bits, no truncation before the compare. Let n = regOutput + STEP.
  - n <= MODULUS-1: regOutput <= n.
  - Otherwise, SAT=0: regOutput <= n - MODULUS.
  - Otherwise, SAT=1: regOutput <= MODULUS-1.
  - A crossing sets wrapEvt for one cycle and sets ovf. In SAT=1 this includes inc while already at MODULUS-1.
- Dec:
  - regOutput >= STEP: regOutput <= regOutput - STEP.
  - Otherwise, SAT=0: regOutput <= regOutput + MODULUS - STEP.
  - Otherwise, SAT=1: regOutput <= 0.
  - A crossing sets wrapEvt and ovf, same as inc.
- Clear: regOutput <= 0 and ovf <= 0. Clear loses to load, inc and dec, so ovf is only cleared when clear actually executes.
- Latency: all outputs are registered. The new count is visible one cycle after the command.
- wrapEvt and loadErr deassert in the cycle after they pulse unless re-triggered.
- Hold: no command, so all state is unchanged and the pulses drop to 0.

Optional Feature:
- Macro COUNTER_REG_SNAPSHOT_EN.
- Defined:
  - Adds ports save (in, 1), restore (in, 1) and shadow (out, WIDTH).
  - Adds a shadow register, reset to RESET_VAL.
  - save copies regOutput (pre-update value) into shadow in the same edge; save works independently of the other commands.
  - restore sits at top priority, above load: regOutput <= shadow, no flags.
  - save and restore together: the count and shadow swap.
  - Used for interrupt return-address saving.
- Undefined: no extra ports or registers; behaviour as above.

Decomposition:
- Shared package cpu_pkg holds:
  - Command encoding localparams CMD_HOLD, CMD_CLEAR, CMD_DEC, CMD_INC, CMD_LOAD, CMD_RESTORE.
  - Default WIDTH.
- Natural sub-module counter_reg_arith: combinational next-value and crossing calculation (WIDTH, STEP, MODULUS, SAT).
  - Instantiated twice, once for the up path and once for the down path.
  - The top module holds the priority mux and the registers.

Test Plan:
- Reset and load: release rst_n, then load=1, regInput=4'b0111 -> regOutput=7 next cycle, all flags 0. Assert rst_n low mid-cycle -> regOutput=0 immediately.
- Wrap: WIDTH=4, MODULUS=10, STEP=3, SAT=0; load 8 then inc -> regOutput=1, wrapEvt pulses 1 cycle, ovf=1 and stays set. Then dec from 1 -> 8, wrapEvt pulses.
- Saturate: SAT=1, MODULUS=10, STEP=3, at 8, inc twice -> 9, 9, wrapEvt each cycle. Then dec from 1 -> 0.
- Priority: load=inc=dec=clear=1 with regInput=5 -> regOutput=5. Then inc=dec=1 -> 5+STEP. Then clear=1 alone -> 0, ovf cleared.
- Load range: MODULUS=10, load 12 -> regOutput unchanged, loadErr pulses once, ovf unchanged.
- Snapshot (COUNTER_REG_SNAPSHOT_EN): at 6, save -> shadow=6. inc to 7, then restore -> 6. save+restore with count 7 and shadow 6 -> count=6, shadow=7.
